if_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the pipelined LEGv8 core.
//  - Holds the PC and issues one request at a time to a variable-latency instruction memory.
//  - Registers each returned 32-bit instruction and its PC for the ID stage, which feeds the

---
 rtl/legv8_pkg.sv | 21 ++
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_skid_buf.sv | 33 +++
 rtl/if_fetch_stage.sv | 116 +++++++++++
 tb/tb_if_fetch_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 pipeline.
// Fetch-state encoding and the IF/ID bundle live here.
package legv8_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port: single outstanding request,
// response flagged by valid.
interface if_fetch_stage_if;
  import legv8_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {instr,pc} holding slot for a response
// that arrives while ID is stalled.
module if_skid_buf
  import legv8_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout,
  output logic   full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      unique case (1'b1)
        clear: full <= 1'b0;
        push: begin
          full <= 1'b1;
          dout <= din;
        end
        pop:     full <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC, fetch FSM, skid slot and IF/ID register.
// One imem request in flight; flush redirects the PC.
module if_fetch_stage
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.master   imem,
  input  logic               stall_id,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              fresh;
  logic              push, pop, clr;
  logic              ld, ld_v;
  logic              skid_full, skid_full_n;
  logic              issue;
  if_id_t            ld_d, skid_dout, rsp;

  assign rsp   = '{instr: imem.rdata, pc: pc};
  assign fresh = (state == WAIT) && imem.valid;

  if_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .din   (rsp),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    ld      = 1'b0;
    ld_v    = 1'b0;
    ld_d    = '{instr: NOP_INSTR, pc: if_id_pc};
    if (flush) begin
      clr     = 1'b1;
      ld      = 1'b1;
      pc_n    = branch_target & ~ADDR_W'(3);
      state_n = (state != REQ && !imem.valid) ? DROP : REQ;
    end else begin
      if (fresh) begin
        pc_n    = pc + ADDR_W'(PC_STEP);
        state_n = REQ;
      end
      if (state == DROP && imem.valid) state_n = REQ;
      if (!stall_id) begin
        ld = 1'b1;
        unique case (1'b1)
          skid_full: begin
            pop  = 1'b1;
            ld_v = 1'b1;
            ld_d = skid_dout;
          end
          fresh: begin
            ld_v = 1'b1;
            ld_d = rsp;
          end
          default: ;
        endcase
      end else if (fresh) begin
        if (if_id_valid) begin
          push = 1'b1;
        end else begin
          ld   = 1'b1;
          ld_v = 1'b1;
          ld_d = rsp;
        end
      end
    end
    skid_full_n = (skid_full | push) & ~pop & ~clr;
    // REQ is folded into the edge that enters it so a
    // request goes out the cycle after the previous response.
    issue = (state_n == REQ) && !skid_full_n;
    if (issue) state_n = WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      imem.req    <= 1'b0;
      imem.addr   <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      imem.req <= issue;
      if (issue) imem.addr <= pc_n;
      if (ld) begin
        if_id_instr <= ld_d.instr;
        if_id_pc    <= ld_d.pc;
        if_id_valid <= ld_v;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random
// stall/flush/latency against an in-order fetch scoreboard.
module tb_if_fetch_stage;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] branch_target = '0;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;

  if_fetch_stage_if imem();

  if_fetch_stage #(
    .RESET_PC (64'h0),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall_id      (stall_id),
    .flush         (flush),
    .branch_target (branch_target),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // Scoreboard: fetch pointer for requests, program-order
  // pointer for ID consumption, count of held instructions.
  logic [63:0] fp, exp_pc, raddr;
  int          held, cnt, consumed, idle;
  bit          pending, stale;
  bit          last_req, last_idv;
  logic [63:0] last_addr, last_idpc;

  task automatic tick(input bit st, input bit fl,
                      input logic [63:0] tg, input int l);
    bit was_pend, resp, resp_stale;
    @(negedge clk);
    last_req  = imem.req;
    last_addr = imem.addr;
    last_idv  = if_id_valid;
    last_idpc = if_id_pc;
    chk("if_id_valid", if_id_valid, held > 0);
    if (!if_id_valid) chk("nop_when_invalid", if_id_instr, NOP_INSTR);
    was_pend = pending;
    if (imem.req) begin
      chk("one_outstanding", was_pend, 0);
      chk("no_req_skid_full", held >= 2, 0);
      chk("req_addr", imem.addr, fp);
      fp = fp + 64'd4;
    end else if (pending) begin
      chk("addr_hold", imem.addr, raddr);
    end
    stall_id      = st;
    flush         = fl;
    branch_target = tg;
    if (if_id_valid && !st && !fl) begin
      chk("id_pc", if_id_pc, exp_pc);
      chk("id_instr", if_id_instr, imem_word(exp_pc));
      exp_pc = exp_pc + 64'd4;
      if (held > 0) held--;
      consumed++;
    end
    imem.valid = 1'b0;
    resp       = 1'b0;
    resp_stale = 1'b0;
    if (was_pend) begin
      cnt--;
      if (cnt == 0) begin
        imem.valid = 1'b1;
        imem.rdata = imem_word(raddr);
        resp       = 1'b1;
        resp_stale = stale;
        pending    = 1'b0;
      end
    end
    if (imem.req) begin
      pending = 1'b1;
      stale   = 1'b0;
      cnt     = l;
      raddr   = imem.addr;
    end
    if (fl) begin
      exp_pc = tg & ~64'd3;
      fp     = tg & ~64'd3;
      held   = 0;
      if (pending) stale = 1'b1;
    end
    if (resp && !resp_stale && !fl) held++;
    if (imem.req || resp) idle = 0;
    else idle++;
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    rst_n      = 1'b0;
    stall_id   = 1'b0;
    flush      = 1'b0;
    imem.valid = 1'b0;
    #1;
    chk("rst_req", imem.req, 0);
    chk("rst_addr", imem.addr, 64'h0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_instr", if_id_instr, NOP_INSTR);
    chk("rst_pc", if_id_pc, 64'h0);
    repeat (2) @(negedge clk);
    fp      = 64'h0;
    exp_pc  = 64'h0;
    held    = 0;
    pending = 1'b0;
    stale   = 1'b0;
    idle    = 0;
    imem.valid = stray;
    imem.rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit st, fl;
    logic [63:0] tg;
    imem.valid = 1'b0;
    imem.rdata = '0;
    consumed   = 0;
    do_reset(1'b0);

    // latency 1: requests every other cycle from 0x0
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, '0, 1);
      chk("t1_req_cycle", last_req, (k % 2) == 0);
      if (last_req) chk("t1_req_addr", last_addr, 64'(k / 2 * 4));
    end

    // stall with 0x4 in IF/ID: 0x8 parks in skid
    tick(1, 0, '0, 1);
    chk("t2_id_pc4", last_idpc, 64'h4);
    chk("t2_req8", last_addr, 64'h8);
    tick(1, 0, '0, 1);
    chk("t2_noreq_a", last_req, 0);
    tick(1, 0, '0, 1);
    chk("t2_noreq_b", last_req, 0);
    tick(0, 0, '0, 3);
    chk("t2_noreq_c", last_req, 0);
    tick(0, 0, '0, 3);
    chk("t2_release_pc", last_idpc, 64'h8);
    chk("t2_release_req", last_req, 1);
    chk("t2_release_addr", last_addr, 64'hC);

    // flush mid-WAIT, latency 3: stale response dropped
    tick(0, 1, 64'h103, 3);
    n = 0;
    do begin
      tick(0, 0, '0, 1);
      n++;
      if (n == 1) chk("t3_flush_nop", last_idv, 0);
    end while (!last_req && n < 20);
    chk("t3_drop_cycles", n, 3);
    chk("t3_target", last_addr, 64'h100);

    // flush in the response cycle: straight to REQ
    tick(0, 1, 64'h2000, 1);
    tick(0, 0, '0, 1);
    chk("t4_req_next", last_req, 1);
    chk("t4_target", last_addr, 64'h2000);

    // PC wrap
    tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    tick(0, 0, '0, 1);
    chk("t5_req_top", last_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    chk("t5_wrap_req", last_req, 1);
    chk("t5_wrap_addr", last_addr, 64'h0);

    // reset mid-WAIT, stray response after release
    tick(0, 0, '0, 3);
    tick(0, 0, '0, 3);
    chk("t6_req", last_req, 1);
    tick(0, 0, '0, 3);
    do_reset(1'b1);
    tick(0, 0, '0, 1);
    chk("t6_first_req", last_req, 1);
    chk("t6_first_addr", last_addr, 64'h0);
    repeat (6) tick(0, 0, '0, 1);

    // random stall / flush / latency
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 99) < 4);
      tg = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tg = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      tick(st, fl, tg, $urandom_range(1, 4));
      if (idle > 60) begin
        chk("watchdog_idle", idle, 0);
        break;
      end
    end
    chk("progress", consumed > 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
